// File: rtl/led_breather_multi.sv
// Multi-channel breathing LED driver: a shared prescaled phase, per-channel offset and
// triangle fold, optional quadratic gamma, and frame-synchronous PWM with mode select.
module led_breather_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned PRESCALE  = 300000,
  parameter int unsigned INVERT    = 1,
  parameter int unsigned GAMMA     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2*CHANNELS-1:0]   mode,
  output logic                    tick,
  output logic [CHANNELS-1:0]     pwm_out
);

  localparam int unsigned W       = PWM_WIDTH;
  localparam int unsigned PW      = W + 1;
  localparam int unsigned PRODW   = 2 * W + 1;
  localparam int unsigned PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PH_STEP = (2 ** PW) / CHANNELS;

  localparam logic [W-1:0]   DUTY_MAX   = {W{1'b1}};
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);
  localparam logic           INV_BIT    = 1'(INVERT);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  logic [PSW-1:0]      presc;
  logic [PW-1:0]       phase;
  logic [W-1:0]        pwm_cnt;
  logic [W-1:0]        duty   [CHANNELS];

  logic [PW-1:0]       ph     [CHANNELS];
  logic [W-1:0]        level  [CHANNELS];
  logic [PRODW-1:0]    prod   [CHANNELS];
  logic [W-1:0]        g_lvl  [CHANNELS];
  logic [W-1:0]        target [CHANNELS];
  logic [CHANNELS-1:0] raw;
  logic                frame_end;
  logic                unused_prod;

  // Prescaler: wraps at PRESCALE-1 and emits a registered one-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        tick  <= 1'b1;
      end else begin
        presc <= presc + PSW'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Shared animation phase, one step per tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + PW'(1);
    end
  end

  // Free-running PWM counter; runs even while the animation is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + W'(1);
    end
  end

  assign frame_end = (pwm_cnt == DUTY_MAX);

  // Per-channel offset, fold, gamma, mode select and PWM compare.
  always_comb begin
    unused_prod = 1'b0;
    raw         = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ph[i]     = phase + PW'(i * PH_STEP);
      level[i]  = ph[i][W] ? ~ph[i][W-1:0] : ph[i][W-1:0];
      prod[i]   = PRODW'(level[i]) * PRODW'({1'b0, level[i]} + PW'(1));
      // level*(level+1) < 2^(2W), so the top bit and the shifted-out bits are dropped.
      g_lvl[i]  = prod[i][2*W-1:W];
      unused_prod = unused_prod ^ prod[i][2*W] ^ (^prod[i][W-1:0]);

      target[i] = '0;
      case (mode[2*i +: 2])
        MODE_OFF:     target[i] = '0;
        MODE_ON:      target[i] = DUTY_MAX;
        MODE_BREATHE: target[i] = (GAMMA != 0) ? g_lvl[i] : level[i];
        MODE_BLINK:   target[i] = ph[i][W] ? DUTY_MAX : '0;
        default:      target[i] = '0;
      endcase

      raw[i] = (duty[i] == DUTY_MAX) ? 1'b1 : (pwm_cnt < duty[i]);
    end
  end

  // Duty registers only change at the frame boundary, so a frame is never cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= '0;
      end
    end else if (frame_end) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= target[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= {CHANNELS{INV_BIT}};
    end else begin
      pwm_out <= raw ^ {CHANNELS{INV_BIT}};
    end
  end

endmodule

// File: tb/tb_led_breather_multi.sv
// Randomised scoreboard bench for led_breather_multi: a behavioural model predicts ticks
// and whole PWM frame waveforms; a negedge monitor compares what the pins actually show.
module tb_led_breather_multi;

  localparam int CH    = 4;
  localparam int W     = 4;
  localparam int P     = 4;
  localparam int INV   = 1;
  localparam int GAM   = 1;
  localparam int MW    = 2 * CH;
  localparam int NPH   = 2 ** (W + 1);
  localparam int MAXV  = 2 ** W - 1;
  localparam int FRAME = 2 ** W;

  localparam logic [CH-1:0] RST_PWM = {CH{1'b1}};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [MW-1:0] mode = '0;
  logic          tick;
  logic [CH-1:0] pwm_out;

  led_breather_multi #(
    .CHANNELS (CH),
    .PWM_WIDTH(W),
    .PRESCALE (P),
    .INVERT   (INV),
    .GAMMA    (GAM)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .tick   (tick),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               ch;
    logic [FRAME-1:0] pat;
  } frame_exp_t;

  frame_exp_t frame_q[$];
  bit         tick_q[$];

  int checks = 0;
  int errors = 0;
  int frames = 0;
  bit done   = 1'b0;

  // Model state, in spec terms: edges since reset, enabled edges, phase, tick.
  int m_cyc    = 0;
  int m_en     = 0;
  int m_phase  = 0;
  bit m_tick   = 1'b0;
  int n_edges  = 0;
  bit in_reset = 1'b0;

  function automatic int exp_duty(int m, int phase, int ch);
    int ph;
    int lvl;
    ph  = (phase + ch * (NPH / CH)) % NPH;
    lvl = (ph >= NPH / 2) ? (NPH - 1 - ph) : ph;
    case (m)
      0:       return 0;
      1:       return MAXV;
      2:       return (GAM != 0) ? (lvl * (lvl + 1)) / (MAXV + 1) : lvl;
      default: return (ph >= NPH / 2) ? MAXV : 0;
    endcase
  endfunction

  function automatic logic [FRAME-1:0] exp_pattern(int duty);
    logic [FRAME-1:0] p;
    for (int k = 0; k < FRAME; k++) begin
      p[k] = ((duty == MAXV) || (k < duty)) ? 1'b1 : 1'b0;
      if (INV != 0) p[k] = ~p[k];
    end
    return p;
  endfunction

  // Reference model: evaluated on every active edge with the inputs the DUT samples.
  always @(posedge clk) begin
    bit new_tick;
    if (reset) begin
      m_cyc    = 0;
      m_en     = 0;
      m_phase  = 0;
      m_tick   = 1'b0;
      n_edges  = 0;
      in_reset = 1'b1;
      frame_q.delete();
      tick_q.delete();
      for (int c = 0; c < CH; c++) frame_q.push_back('{c, exp_pattern(0)});
    end else begin
      in_reset = 1'b0;
      if (m_cyc % FRAME == FRAME - 1) begin
        for (int c = 0; c < CH; c++)
          frame_q.push_back('{c, exp_pattern(exp_duty(int'(mode[2*c +: 2]), m_phase, c))});
      end
      new_tick = enable && (m_en % P == P - 1);
      if (enable) m_en = m_en + 1;
      m_phase = (m_phase + int'(m_tick)) % NPH;
      m_tick  = new_tick;
      tick_q.push_back(new_tick);
      m_cyc   = m_cyc + 1;
      n_edges = n_edges + 1;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: samples the pins on the falling edge and pops expectations.
  logic [FRAME-1:0] acc [CH];
  always @(negedge clk) begin
    int k;
    frame_exp_t e;
    bit t;
    if (in_reset) begin
      check("reset_pwm", 32'(pwm_out), 32'(RST_PWM));
      check("reset_tick", 32'(tick), 32'd0);
    end else if (n_edges > 0) begin
      if (tick_q.size() == 0) begin
        check("tick_queue_empty", 32'd1, 32'd0);
      end else begin
        t = tick_q.pop_front();
        check("tick", 32'(tick), 32'(t));
      end
      k = (n_edges - 1) % FRAME;
      for (int c = 0; c < CH; c++) acc[c][k] = pwm_out[c];
      if (k == FRAME - 1) begin
        frames = frames + 1;
        for (int c = 0; c < CH; c++) begin
          if (frame_q.size() == 0) begin
            check("frame_queue_empty", 32'd1, 32'd0);
          end else begin
            e = frame_q.pop_front();
            check($sformatf("frame_ch%0d", e.ch), 32'(acc[e.ch]), 32'(e.pat));
          end
        end
      end
    end
    if (done) begin
      check("frames_seen_enough", 32'(frames >= 200), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed phases (reset, static, blink, freeze) then random segments.
  initial begin
    mode   = 8'hAA;
    reset  = 1'b1;
    enable = 1'b1;
    run(3);
    reset = 1'b0;
    run(200);
    mode = 8'b00_00_00_01;
    run(107);
    mode = 8'h00;
    run(60);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(40);
    mode = 8'hFF;
    run(300);
    enable = 1'b0;
    run(50);
    enable = 1'b1;
    run(150);
    mode = 8'hAA;
    run(300);
    for (int s = 0; s < 40; s++) begin
      mode   = MW'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
      end
      run($urandom_range(5, 200));
    end
    enable = 1'b1;
    mode   = 8'hAA;
    run(600);
    done = 1'b1;
    run(10);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
